// File: rtl/inst_fetch_buffer.sv
// Instruction-fetch front end: owns the PC, drives the combinational instruction
// ROM and queues fetched words with their PCs in a small prefetch FIFO that feeds
// decode over a valid/ready handshake. A branch redirect flushes the queue and
// reloads the PC from the target.
module inst_fetch_buffer #(
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                       clk,
    input  logic                       rst,
    output logic                       rom_ce_o,
    output logic [31:0]                rom_addr_o,
    input  logic [31:0]                rom_data_i,
    input  logic                       branch_flag_i,
    input  logic [31:0]                branch_target_addr_i,
    output logic                       inst_valid_o,
    output logic [31:0]                inst_o,
    output logic [31:0]                inst_pc_o,
    input  logic                       id_ready_i,
    output logic [$clog2(DEPTH):0]     fifo_count_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    logic [31:0]      pc;
    logic [PTR_W-1:0] rd_ptr;
    logic [PTR_W-1:0] wr_ptr;
    logic [CNT_W-1:0] count;
    logic [31:0]      mem_inst [DEPTH];
    logic [31:0]      mem_pc   [DEPTH];
    logic             push;
    logic             pop;
    logic             not_empty;

    // A fetch is only issued against the registered count, so a pop in the
    // same cycle cannot free a slot early; a redirect suppresses both sides.
    assign not_empty    = (count != '0);
    assign push         = rst & ~branch_flag_i & (count < DEPTH_C);
    assign pop          = not_empty & id_ready_i & ~branch_flag_i;

    assign rom_ce_o     = push;
    assign rom_addr_o   = pc;
    assign inst_valid_o = not_empty;
    assign fifo_count_o = count;

    // Head entry is gated by valid so stale storage never reaches decode.
    always_comb begin
        inst_o    = 32'h0;
        inst_pc_o = 32'h0;
        if (not_empty) begin
            inst_o    = mem_inst[rd_ptr];
            inst_pc_o = mem_pc[rd_ptr];
        end
    end

    // PC advances by one word per fetch and is reloaded (word aligned) on redirect.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pc <= RESET_PC;
        end else if (branch_flag_i) begin
            pc <= {branch_target_addr_i[31:2], 2'b00};
        end else if (push) begin
            pc <= pc + 32'd4;
        end
    end

    // Pointers wrap naturally; count is kept separately to tell full from empty.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (branch_flag_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage needs no reset because every read is qualified by the count.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_inst[wr_ptr] <= rom_data_i;
            mem_pc[wr_ptr]   <= pc;
        end
    end

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Self-checking bench for inst_fetch_buffer: directed scenarios plus a
// randomized run compared against a queue-based reference model.
module tb_inst_fetch_buffer;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } entry_t;

    logic        clk;
    logic        rst;
    logic        rom_ce;
    logic [31:0] rom_addr;
    logic [31:0] rom_data;
    logic        branch_flag;
    logic [31:0] branch_target;
    logic        inst_valid;
    logic [31:0] inst;
    logic [31:0] inst_pc;
    logic        id_ready;
    logic [2:0]  fifo_count;

    int checks = 0;
    int errors = 0;

    entry_t      model_q[$];
    logic [31:0] model_pc;

    inst_fetch_buffer #(.DEPTH(4), .RESET_PC(RESET_PC)) dut (
        .clk                  (clk),
        .rst                  (rst),
        .rom_ce_o             (rom_ce),
        .rom_addr_o           (rom_addr),
        .rom_data_i           (rom_data),
        .branch_flag_i        (branch_flag),
        .branch_target_addr_i (branch_target),
        .inst_valid_o         (inst_valid),
        .inst_o               (inst),
        .inst_pc_o            (inst_pc),
        .id_ready_i           (id_ready),
        .fifo_count_o         (fifo_count)
    );

    // Combinational ROM: word content derived from the address.
    function automatic logic [31:0] rom_word(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign rom_data = rom_word(rom_addr);

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: next state from current inputs, by the fetch/drain rules.
    task automatic model_advance();
        logic was_full;
        if (branch_flag) begin
            model_q.delete();
            model_pc = {branch_target[31:2], 2'b00};
        end else begin
            was_full = (model_q.size() >= 4);
            if (model_q.size() != 0 && id_ready) begin
                void'(model_q.pop_front());
            end
            if (!was_full) begin
                model_q.push_back('{pc: model_pc, inst: rom_word(model_pc)});
                model_pc = model_pc + 32'd4;
            end
        end
    endtask

    task automatic model_reset();
        model_q.delete();
        model_pc = RESET_PC;
    endtask

    // Drive one cycle's inputs at the falling edge, settle, then return for checks.
    task automatic applyStimulus(input logic b, input logic [31:0] t, input logic r);
        @(negedge clk);
        branch_flag   = b;
        branch_target = t;
        id_ready      = r;
        #1;
    endtask

    // Hold reset over a couple of edges, release it just after a rising edge.
    task automatic do_reset();
        @(negedge clk);
        rst         = 1'b0;
        branch_flag = 1'b0;
        id_ready    = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst         = 1'b0;
        branch_flag = 1'b0;
        id_ready    = 1'b1;
        #1;
        checks++;
        if (rom_ce !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_ce: got %b want 0", rom_ce);
        end
        checks++;
        if (inst_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL reset_valid: got %b want 0", inst_valid);
        end
        checks++;
        if (inst !== 32'h0 || inst_pc !== 32'h0) begin
            errors++; $display("[TB] FAIL reset_head: got inst %h pc %h want 0/0", inst, inst_pc);
        end
        checks++;
        if (fifo_count !== 3'd0) begin
            errors++; $display("[TB] FAIL reset_count: got %0d want 0", fifo_count);
        end
    endtask

    task automatic test_stream();
        do_reset();
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b1);
            checks++;
            if (rom_ce !== 1'b1 || rom_addr !== 32'(4 * i)) begin
                errors++; $display("[TB] FAIL stream_fetch[%0d]: got ce %b addr %h want 1/%h", i, rom_ce, rom_addr, 32'(4 * i));
            end
            if (i >= 1) begin
                checks++;
                if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * (i - 1)) || inst !== rom_word(32'(4 * (i - 1)))) begin
                    errors++; $display("[TB] FAIL stream_head[%0d]: got v %b pc %h inst %h want pc %h", i, inst_valid, inst_pc, inst, 32'(4 * (i - 1)));
                end
                checks++;
                if (fifo_count !== 3'd1) begin
                    errors++; $display("[TB] FAIL stream_count[%0d]: got %0d want 1", i, fifo_count);
                end
            end
            model_advance();
        end
    endtask

    task automatic test_backpressure();
        do_reset();
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0);
            checks++;
            if (rom_ce !== (i < 4) || fifo_count !== 3'((i < 4) ? i : 4)) begin
                errors++; $display("[TB] FAIL bp_fill[%0d]: got ce %b cnt %0d want %b/%0d", i, rom_ce, fifo_count, (i < 4), (i < 4) ? i : 4);
            end
            model_advance();
        end
        for (int j = 0; j < 5; j++) begin
            applyStimulus(1'b0, 32'h0, 1'b1);
            checks++;
            if (inst_valid !== 1'b1 || inst_pc !== 32'(4 * j)) begin
                errors++; $display("[TB] FAIL bp_drain[%0d]: got v %b pc %h want 1/%h", j, inst_valid, inst_pc, 32'(4 * j));
            end
            if (j == 0) begin
                checks++;
                if (rom_ce !== 1'b0) begin
                    errors++; $display("[TB] FAIL bp_no_fetch_at_full: got ce %b want 0", rom_ce);
                end
            end
            if (j == 1) begin
                checks++;
                if (rom_ce !== 1'b1 || rom_addr !== 32'h10) begin
                    errors++; $display("[TB] FAIL bp_resume: got ce %b addr %h want 1/00000010", rom_ce, rom_addr);
                end
            end
            model_advance();
        end
    endtask

    task automatic test_full_pop();
        do_reset();
        for (int i = 0; i < 4; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0);
            model_advance();
        end
        applyStimulus(1'b0, 32'h0, 1'b1);
        checks++;
        if (fifo_count !== 3'd4 || rom_ce !== 1'b0) begin
            errors++; $display("[TB] FAIL full_pop_cycle: got cnt %0d ce %b want 4/0", fifo_count, rom_ce);
        end
        model_advance();
        applyStimulus(1'b0, 32'h0, 1'b0);
        checks++;
        if (fifo_count !== 3'd3 || rom_ce !== 1'b1 || rom_addr !== 32'h10) begin
            errors++; $display("[TB] FAIL full_pop_refetch: got cnt %0d ce %b addr %h want 3/1/00000010", fifo_count, rom_ce, rom_addr);
        end
        model_advance();
        applyStimulus(1'b0, 32'h0, 1'b0);
        checks++;
        if (fifo_count !== 3'd4 || inst_pc !== 32'h4) begin
            errors++; $display("[TB] FAIL full_pop_refill: got cnt %0d head %h want 4/00000004", fifo_count, inst_pc);
        end
        model_advance();
    endtask

    task automatic test_branch();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0);
            model_advance();
        end
        applyStimulus(1'b1, 32'h0000_0103, 1'b1);
        checks++;
        if (rom_ce !== 1'b0 || fifo_count !== 3'd3 || inst_pc !== 32'h0) begin
            errors++; $display("[TB] FAIL branch_cycle: got ce %b cnt %0d head %h want 0/3/00000000", rom_ce, fifo_count, inst_pc);
        end
        model_advance();
        applyStimulus(1'b0, 32'h0, 1'b1);
        checks++;
        if (fifo_count !== 3'd0 || inst_valid !== 1'b0 || rom_ce !== 1'b1 || rom_addr !== 32'h100) begin
            errors++; $display("[TB] FAIL branch_flush: got cnt %0d v %b ce %b addr %h want 0/0/1/00000100", fifo_count, inst_valid, rom_ce, rom_addr);
        end
        model_advance();
        applyStimulus(1'b0, 32'h0, 1'b1);
        checks++;
        if (inst_valid !== 1'b1 || inst_pc !== 32'h100 || inst !== rom_word(32'h100)) begin
            errors++; $display("[TB] FAIL branch_target_head: got v %b pc %h inst %h want 1/00000100", inst_valid, inst_pc, inst);
        end
        model_advance();
    endtask

    task automatic test_wrap();
        logic [31:0] exp_addr [4];
        exp_addr[0] = 32'hFFFF_FFF8;
        exp_addr[1] = 32'hFFFF_FFFC;
        exp_addr[2] = 32'h0000_0000;
        exp_addr[3] = 32'h0000_0004;
        do_reset();
        applyStimulus(1'b1, 32'hFFFF_FFF8, 1'b1);
        model_advance();
        for (int k = 0; k < 5; k++) begin
            applyStimulus(1'b0, 32'h0, 1'b1);
            if (k < 4) begin
                checks++;
                if (rom_ce !== 1'b1 || rom_addr !== exp_addr[k]) begin
                    errors++; $display("[TB] FAIL wrap_fetch[%0d]: got ce %b addr %h want 1/%h", k, rom_ce, rom_addr, exp_addr[k]);
                end
            end
            if (k >= 1) begin
                checks++;
                if (inst_pc !== exp_addr[k - 1]) begin
                    errors++; $display("[TB] FAIL wrap_head[%0d]: got %h want %h", k, inst_pc, exp_addr[k - 1]);
                end
            end
            model_advance();
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b0, 32'h0, 1'b0);
            model_advance();
        end
        @(posedge clk);
        #3 rst = 1'b0;
        #1;
        model_reset();
        checks++;
        if (inst_valid !== 1'b0 || rom_ce !== 1'b0 || fifo_count !== 3'd0 || inst !== 32'h0) begin
            errors++; $display("[TB] FAIL async_reset: got v %b ce %b cnt %0d inst %h want 0/0/0/0", inst_valid, rom_ce, fifo_count, inst);
        end
        @(posedge clk);
        #2 rst = 1'b1;
        applyStimulus(1'b0, 32'h0, 1'b1);
        checks++;
        if (rom_ce !== 1'b1 || rom_addr !== RESET_PC) begin
            errors++; $display("[TB] FAIL async_restart: got ce %b addr %h want 1/%h", rom_ce, rom_addr, RESET_PC);
        end
        model_advance();
    endtask

    // Random handshake and redirect traffic compared cycle by cycle with the model.
    task automatic test_random();
        logic [31:0] exp_inst;
        logic [31:0] exp_pc;
        logic        exp_valid;
        logic        exp_ce;
        do_reset();
        for (int c = 0; c < 400; c++) begin
            applyStimulus(($urandom_range(0, 9) == 0), $urandom, ($urandom_range(0, 2) != 0));
            exp_valid = (model_q.size() != 0);
            exp_inst  = exp_valid ? model_q[0].inst : 32'h0;
            exp_pc    = exp_valid ? model_q[0].pc : 32'h0;
            exp_ce    = !branch_flag && (model_q.size() < 4);
            checks++;
            if (rom_ce !== exp_ce || rom_addr !== model_pc) begin
                errors++; $display("[TB] FAIL rand_fetch[%0d]: got ce %b addr %h want %b/%h", c, rom_ce, rom_addr, exp_ce, model_pc);
            end
            checks++;
            if (inst_valid !== exp_valid || inst !== exp_inst || inst_pc !== exp_pc) begin
                errors++; $display("[TB] FAIL rand_head[%0d]: got v %b inst %h pc %h want %b/%h/%h", c, inst_valid, inst, inst_pc, exp_valid, exp_inst, exp_pc);
            end
            checks++;
            if (fifo_count !== 3'(model_q.size())) begin
                errors++; $display("[TB] FAIL rand_count[%0d]: got %0d want %0d", c, fifo_count, model_q.size());
            end
            model_advance();
        end
    endtask

    initial begin
        rst           = 1'b0;
        branch_flag   = 1'b0;
        branch_target = 32'h0;
        id_ready      = 1'b0;
        model_reset();
        test_reset();
        test_stream();
        test_backpressure();
        test_full_pop();
        test_branch();
        test_wrap();
        test_async_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
